// File: rtl/tagged_frame_unpacker.sv
// rtl/tagged_frame_unpacker.sv - rebuilds byte-serial {tag, len, payload} frames into one parallel word
// Malformed headers (len 0 or len > DATA_BYTES) are dropped with an error pulse and a saturating count.
module tagged_frame_unpacker #(
  parameter int DATA_BYTES = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [1:0]              m_tag,
  output logic [5:0]              m_len,
  output logic [8*DATA_BYTES-1:0] m_data,
  output logic                    err_pulse,
  output logic [ERR_CNT_W-1:0]    err_count
);

  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_DROP, S_OUT} state_t;

  localparam logic [5:0]           LP_MAX_LEN = 6'(DATA_BYTES);
  localparam logic [ERR_CNT_W-1:0] LP_ERR_ONE = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] LP_ERR_MAX = {ERR_CNT_W{1'b1}};

  state_t                    r_state;
  logic                      r_s_ready;
  logic                      r_m_valid;
  logic [1:0]                r_tag;
  logic [5:0]                r_len;
  logic [5:0]                r_idx;
  logic [5:0]                r_drop;
  logic [8*DATA_BYTES-1:0]   r_data;
  logic                      r_err_pulse;
  logic [ERR_CNT_W-1:0]      r_err_count;

  logic                      w_fire;
  logic [5:0]                w_hdr_len;
  logic                      w_hdr_err;

  assign w_fire    = s_valid && r_s_ready;
  assign w_hdr_len = s_data[5:0];
  assign w_hdr_err = (r_state == S_HDR) && w_fire &&
                     ((w_hdr_len == 6'd0) || (w_hdr_len > LP_MAX_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HDR;
      r_s_ready   <= 1'b1;
      r_m_valid   <= 1'b0;
      r_tag       <= 2'd0;
      r_len       <= 6'd0;
      r_idx       <= 6'd0;
      r_drop      <= 6'd0;
      r_data      <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_err_pulse <= w_hdr_err;
      if (w_hdr_err && (r_err_count != LP_ERR_MAX)) begin
        r_err_count <= r_err_count + LP_ERR_ONE;
      end

      case (r_state)
        S_HDR: begin
          if (w_fire && !w_hdr_err) begin
            r_tag   <= s_data[7:6];
            r_len   <= w_hdr_len;
            r_data  <= '0;
            r_idx   <= 6'd0;
            r_state <= S_PAYLOAD;
          end else if (w_fire && (w_hdr_len != 6'd0)) begin
            r_drop  <= w_hdr_len;
            r_state <= S_DROP;
          end
        end
        S_PAYLOAD: begin
          if (w_fire) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
              if (r_idx == 6'(b)) r_data[8*b +: 8] <= s_data;
            end
            r_idx <= r_idx + 6'd1;
            if (r_idx == r_len - 6'd1) begin
              r_state   <= S_OUT;
              r_s_ready <= 1'b0;
              r_m_valid <= 1'b1;
            end
          end
        end
        S_DROP: begin
          if (w_fire) begin
            r_drop <= r_drop - 6'd1;
            if (r_drop == 6'd1) r_state <= S_HDR;
          end
        end
        S_OUT: begin
          // s_ready only returns after the frame leaves, so OUT never overlaps the next header
          if (m_ready) begin
            r_state   <= S_HDR;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
          end
        end
        default: r_state <= S_HDR;
      endcase
    end
  end

  assign s_ready   = r_s_ready;
  assign m_valid   = r_m_valid;
  assign m_tag     = r_tag;
  assign m_len     = r_len;
  assign m_data    = r_data;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_tagged_frame_unpacker.sv
// tb/tb_tagged_frame_unpacker.sv - scoreboard bench for tagged_frame_unpacker
// Frame-level model predicts outputs; a negedge monitor pops and compares.
module tb_tagged_frame_unpacker;
  localparam int DB  = 4;
  localparam int EW  = 2;
  localparam int SAT = 3;

  typedef struct packed {
    logic [1:0]  tag;
    logic [5:0]  len;
    logic [31:0] data;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [7:0]    s_data = 8'h00;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [1:0]    m_tag;
  logic [5:0]    m_len;
  logic [31:0]   m_data;
  logic          err_pulse;
  logic [EW-1:0] err_count;

  int     checks = 0;
  int     failures = 0;
  frame_t exp_q[$];
  int     err_q[$];
  int     model_errs = 0;
  bit     rdy_rand = 1'b0;
  bit     use_gaps = 1'b0;
  logic [7:0] pbuf [64];
  frame_t held;
  bit     prev_hold = 1'b0;

  tagged_frame_unpacker #(.DATA_BYTES(DB), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_tag(m_tag), .m_len(m_len), .m_data(m_data),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rdy_rand) begin
      #1;
      m_ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    frame_t e;
    int     ec;
    if (!rst_n) begin
      chk("reset_outputs", {m_valid, m_tag, m_len, m_data, err_pulse, err_count}, 64'd0);
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) chk("hold_stable", {m_valid, m_tag, m_len, m_data}, {1'b1, held});
      if (m_valid) chk("s_ready_low_in_out", s_ready, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame actual=%0h required=none", {m_tag, m_len, m_data});
        end else begin
          e = exp_q.pop_front();
          chk("frame", {m_tag, m_len, m_data}, e);
        end
      end
      prev_hold = m_valid && !m_ready;
      held = {m_tag, m_len, m_data};
      if (err_pulse) begin
        if (err_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_err_pulse actual=1 required=0");
        end else begin
          ec = err_q.pop_front();
          chk("err_count", err_count, ec);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    bit ok;
    gap = (use_gaps && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL byte_accept_timeout actual=stalled required=accepted byte=%0h", b);
    end
    s_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hdr);
    int          len;
    logic [31:0] d;
    frame_t      f;
    len = int'(hdr[5:0]);
    if (len == 0 || len > DB) begin
      model_errs++;
      err_q.push_back(model_errs > SAT ? SAT : model_errs);
    end else begin
      d = 32'd0;
      for (int i = 0; i < len; i++) d = d | (32'(pbuf[i]) << (8 * i));
      f.tag = hdr[7:6];
      f.len = hdr[5:0];
      f.data = d;
      exp_q.push_back(f);
    end
    send_byte(hdr);
    for (int i = 0; i < len; i++) send_byte(pbuf[i]);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && (exp_q.size() != 0 || err_q.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    chk(name, exp_q.size() + err_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    model_errs = 0;
    @(negedge clk);
    chk("post_reset_s_ready", s_ready, 1);
    chk("post_reset_m_valid", m_valid, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    @(posedge clk); #1;
    do_reset();

    // single frame, latency and one-cycle m_valid
    m_ready = 1'b1;
    pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33;
    send_frame(8'h83);
    @(negedge clk);
    chk("latency_m_valid", m_valid, 1);
    @(negedge clk);
    chk("m_valid_one_cycle", m_valid, 0);
    chk("err_count_zero", err_count, 0);
    @(posedge clk); #1;

    // backpressure
    m_ready = 1'b0;
    send_frame(8'h83);
    repeat (5) begin
      @(negedge clk);
      chk("bp_m_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 0);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_s_ready_after", s_ready, 1);
    @(posedge clk); #1;
    pbuf[0] = 8'hAA;
    send_frame(8'h41);
    drain("drain_bp");

    // zero length then valid frame
    send_frame(8'hC0);
    pbuf[0] = 8'h55; pbuf[1] = 8'h66;
    send_frame(8'h42);
    drain("drain_zero");
    chk("zero_err_count", err_count, 1);

    // oversize: 5 junk bytes dropped
    for (int i = 0; i < 5; i++) pbuf[i] = 8'(8'hE0 + i);
    send_frame(8'h05);
    pbuf[0] = 8'h7E;
    send_frame(8'h01);
    drain("drain_oversize");

    // reset mid-frame
    send_byte(8'h84);
    send_byte(8'h01);
    send_byte(8'h02);
    do_reset();
    pbuf[0] = 8'h99;
    send_frame(8'h01);
    drain("drain_midreset");

    // saturation
    do_reset();
    repeat (5) send_frame(8'h00);
    drain("drain_sat");
    chk("sat_err_count", err_count, 3);

    // randomized frames with gaps and random backpressure
    do_reset();
    use_gaps = 1'b1;
    rdy_rand = 1'b1;
    repeat (60) begin
      logic [7:0] hdr;
      hdr = {2'($urandom_range(0, 3)), 6'($urandom_range(0, 6))};
      for (int i = 0; i < 8; i++) pbuf[i] = 8'($urandom);
      send_frame(hdr);
    end
    drain("drain_random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
